sw_led_ctrl: RTL and testbench
==============================

# sw_led_ctrl

Parametrised switch-to-LED controller for the lab board I/O path. It replaces the direct switch-to-LED wire with a multi-channel block that synchronises and debounces each switch. Each LED either follows its debounced switch or toggles on each debounced rising edge. It sits between the board switch pins and the LED pins, and exports the debounced levels and edge pulses to downstream lab logic.

## Interface
- `N`, default 8: number of switch/LED channels, range 1..32.
- `SYNC_STAGES`, default 2: synchroniser flop count per channel, minimum 2.
- `DB_CYCLES`, default 4: consecutive cycles a synchronised value must differ from the stable value before it is accepted, minimum 1.
- `clk`, input, 1: single system clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `sw`, input, N: raw asynchronous switch pins.
- `mode`, input, 1: output mode, 0 = follow, 1 = toggle. Synchronous to `clk`.
- `ld`, output, N: registered LED drive.
- `sw_stable`, output, N: registered debounced switch level.
- `sw_rise`, output, N: one-cycle pulse on each debounced 0→1 transition.

## Operation
- Per channel, a `SYNC_STAGES`-deep flop chain produces `s`.
- Each channel has a counter `cnt` of width `$clog2(DB_CYCLES+1)`.
  - If `s == sw_stable`: `cnt` ← 0.
  - Otherwise `cnt` increments. When `cnt == DB_CYCLES-1`, `sw_stable` ← `s` and `cnt` ← 0.
  - `cnt` therefore never exceeds `DB_CYCLES-1`, so it cannot wrap.
- A glitch that returns to `sw_stable` before the count completes clears `cnt`; no partial credit is kept.
- `sw_rise[i]` is registered and asserts in the same cycle `sw_stable[i]` goes 0→1. It is deasserted in every other cycle.
- Falling transitions produce no pulse.
- `ld` update rule, evaluated each cycle per channel:
  - `mode == 0`: `ld` ← `sw_stable`.
  - `mode == 1`: `ld` ← `~ld` if `sw_rise`, else `ld`.
- Mode change 1→0: `ld` takes `sw_stable` on the next edge.
- Mode change 0→1: `ld` holds its current value; subsequent rises toggle it.
- If a rise and a mode change occur in the same cycle, the `mode` value sampled that cycle selects the rule.
- Channels are fully independent; there is no shared state between channels.

## Timing
- Reset (asynchronous, immediate) sets every flop to 0: sync chains, `cnt`, `sw_stable`, `sw_rise`, `ld`.
- A switch held high through reset is seen as a rise once latency elapses. This is intentional: the LED state is rebuilt from the switches.
- Latency from the first clock edge sampling the new `sw` level:
  - `sw_stable` / `sw_rise`: `SYNC_STAGES + DB_CYCLES` edges.
  - `ld`: one further edge.
  - With defaults: 6 edges to `sw_stable`, 7 edges to `ld`.
- Reset asserted mid-count clears `cnt` and all outputs. After release, debouncing restarts from 0.
- Minimum accepted pulse width is `DB_CYCLES` synchronised cycles; any shorter pulse is filtered.

## Configuration
- `SW_LED_TOGGLE_EN`
  - Defined: toggle mode is implemented as above.
  - Undefined: the `mode` port exists but is ignored; `ld` ← `sw_stable` always, and the toggle logic is not synthesised.
  - `sw_rise` is present in both builds.

## Structure
- Package `sw_led_pkg` holds:
  - `MODE_FOLLOW` = 1'b0 and `MODE_TOGGLE` = 1'b1.
  - The parameter legality ranges above, checked by elaboration-time assertions.
- Sub-module `sw_debounce` is a single channel: sync chain, counter, `sw_stable`, `sw_rise`.
- `sw_led_ctrl` instantiates `N` copies in a generate loop and adds the `ld` mode logic.

## Test plan
- Glitch filter: defaults, `mode`=0, `sw[0]` high for 3 cycles then low → `sw_stable[0]` stays 0, `sw_rise` never asserts, `ld[0]` stays 0.
- Clean press: `sw[3]` 0→1 and held → `sw_stable[3]`=1 and `sw_rise[3]`=1 for exactly one cycle at edge 6, `ld[3]`=1 at edge 7; other channels unchanged.
- Toggle: `mode`=1, two clean presses on `sw[1]` (each held 10 cycles, 10 cycles apart) → `ld[1]` goes 0→1→0, one toggle per rise. Releases cause no toggle.
- Mode switch: `mode`=1 with `ld[2]`=1 and `sw[2]` low, set `mode`=0 → `ld[2]`=0 next edge; set `mode`=1 again → `ld[2]` holds 0.
- Reset mid-count: `sw[5]` high for 4 cycles, assert `rst_n`=0 for 1 cycle, keep `sw[5]` high → all outputs 0 immediately; `sw_stable[5]`=1 exactly 6 edges after release.
- Build without `SW_LED_TOGGLE_EN`: `mode`=1, clean press/release on `sw[0]` → `ld[0]` follows `sw_stable[0]` (1 then 0).

Source files
------------

// File: rtl/sw_led_pkg.sv
// Shared constants for the switch-to-LED controller: mode encodings and
// parameter legality limits checked at elaboration by sw_debounce / sw_led_ctrl.
package sw_led_pkg;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  localparam int N_MIN           = 1;
  localparam int N_MAX           = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int DB_CYCLES_MIN   = 1;

  function automatic bit n_ok(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/sw_led_ctrl_if.sv
// Board-side bundle of the switch/LED controller. The lab board (master) drives
// the raw switches and mode; the controller (slave) returns LED drive and the
// debounced level/edge vectors. There is no handshake: every signal is a level
// sampled on each rising clk edge.
interface sw_led_ctrl_if #(
  parameter int N = 8
) ();
  logic [N-1:0] sw;
  logic         mode;
  logic [N-1:0] ld;
  logic [N-1:0] sw_stable;
  logic [N-1:0] sw_rise;

  modport master (
    output sw, mode,
    input  ld, sw_stable, sw_rise
  );

  modport slave (
    input  sw, mode,
    output ld, sw_stable, sw_rise
  );
endinterface

// File: rtl/sw_debounce.sv
// Single-channel switch conditioner: SYNC_STAGES-deep synchroniser, a
// DB_CYCLES-long debounce counter, registered stable level and rising-edge pulse.
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("sw_debounce: SYNC_STAGES must be at least 2");
  end
  if (DB_CYCLES < DB_CYCLES_MIN) begin : g_bad_db
    $error("sw_debounce: DB_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where s agrees with the stable level wipes the count, so a
  // glitch keeps no partial credit; acceptance happens on the DB_CYCLES-th
  // consecutive disagreeing cycle and the counter never exceeds CNT_MAX.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sw_i};
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s;
        rise_d   = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// N-channel switch-to-LED controller: per-channel debounce plus LED follow or
// toggle logic. Toggle mode exists only when SW_LED_TOGGLE_EN is defined.
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sw_led_ctrl_if.slave   bus
);

  if (!n_ok(N)) begin : g_bad_n
    $error("sw_led_ctrl: N must be in 1..32");
  end

  logic [N-1:0] stable;
  logic [N-1:0] rise;
  logic [N-1:0] ld_q, ld_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sw_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_i     (bus.sw[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i])
    );
  end

`ifdef SW_LED_TOGGLE_EN
  // mode is sampled in the same cycle as the rise pulse, so it alone picks the rule.
  always_comb begin
    ld_d = stable;
    if (bus.mode == MODE_TOGGLE) begin
      ld_d = ld_q ^ rise;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  always_comb begin
    ld_d = stable;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= '0;
    end else begin
      ld_q <= ld_d;
    end
  end

  assign bus.ld        = ld_q;
  assign bus.sw_stable = stable;
  assign bus.sw_rise   = rise;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl (defaults N=8, SYNC_STAGES=2, DB_CYCLES=4).
// Toggle-mode sequences are compiled only when SW_LED_TOGGLE_EN is defined.
module tb_sw_led_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sw_led_ctrl_if #(.N(8)) bus ();

  sw_led_ctrl #(
    .N           (8),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic       mode;
    int         steps;
    logic [7:0] e_st;
    logic [7:0] e_rise;
    logic [7:0] e_ld;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic [7:0] ri,
                         input logic [7:0] ld);
    chk({tag, ".sw_stable"}, bus.sw_stable, st);
    chk({tag, ".sw_rise"},   bus.sw_rise,   ri);
    chk({tag, ".ld"},        bus.ld,        ld);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.sw  = 8'h00;
    bus.mode = 1'b0;

    // glitch filter, minimum accepted pulse, clean press on sw[3], multi-channel
    vecs[0]  = '{8'h00, 1'b0, 2, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{8'h01, 1'b0, 3, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{8'h00, 1'b0, 6, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{8'h01, 1'b0, 4, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{8'h00, 1'b0, 2, 8'h01, 8'h01, 8'h00};
    vecs[5]  = '{8'h00, 1'b0, 1, 8'h01, 8'h00, 8'h01};
    vecs[6]  = '{8'h00, 1'b0, 2, 8'h01, 8'h00, 8'h01};
    vecs[7]  = '{8'h00, 1'b0, 1, 8'h00, 8'h00, 8'h01};
    vecs[8]  = '{8'h00, 1'b0, 1, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{8'h08, 1'b0, 5, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{8'h08, 1'b0, 1, 8'h08, 8'h08, 8'h00};
    vecs[11] = '{8'h08, 1'b0, 1, 8'h08, 8'h00, 8'h08};
    vecs[12] = '{8'h08, 1'b0, 3, 8'h08, 8'h00, 8'h08};
    vecs[13] = '{8'h00, 1'b0, 6, 8'h00, 8'h00, 8'h08};
    vecs[14] = '{8'h00, 1'b0, 1, 8'h00, 8'h00, 8'h00};
    vecs[15] = '{8'hA5, 1'b0, 6, 8'hA5, 8'hA5, 8'h00};
    vecs[16] = '{8'hA5, 1'b0, 1, 8'hA5, 8'h00, 8'hA5};
    vecs[17] = '{8'h00, 1'b0, 7, 8'h00, 8'h00, 8'h00};

    step(2);
    chk_all("reset", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus.sw   = vecs[i].sw;
      bus.mode = vecs[i].mode;
      step(vecs[i].steps);
      chk_all($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_rise, vecs[i].e_ld);
    end

`ifdef SW_LED_TOGGLE_EN
    // two presses on sw[1] in toggle mode; releases must not toggle
    bus.mode = 1'b1;
    bus.sw   = 8'h02;
    step(6);
    chk_all("tog_p1_rise", 8'h02, 8'h02, 8'h00);
    step(1);
    chk_all("tog_p1_ld", 8'h02, 8'h00, 8'h02);
    step(3);
    bus.sw = 8'h00;
    step(10);
    chk_all("tog_r1", 8'h00, 8'h00, 8'h02);
    bus.sw = 8'h02;
    step(7);
    chk_all("tog_p2", 8'h02, 8'h00, 8'h00);
    step(3);
    bus.sw = 8'h00;
    step(10);
    chk_all("tog_r2", 8'h00, 8'h00, 8'h00);

    // mode switch with ld[2]=1 and sw[2] low
    bus.sw = 8'h04;
    step(7);
    chk("ms_set.ld", bus.ld, 8'h04);
    bus.sw = 8'h00;
    step(8);
    chk_all("ms_rel", 8'h00, 8'h00, 8'h04);
    bus.mode = 1'b0;
    step(1);
    chk("ms_to_follow.ld", bus.ld, 8'h00);
    bus.mode = 1'b1;
    step(3);
    chk("ms_to_toggle.ld", bus.ld, 8'h00);
    bus.sw = 8'h04;
    step(7);
    chk("ms_retoggle.ld", bus.ld, 8'h04);
    bus.sw = 8'h00;
    step(8);
    chk("ms_retoggle_rel.ld", bus.ld, 8'h04);
    bus.mode = 1'b0;
    step(1);
    chk("ms_back.ld", bus.ld, 8'h00);
`else
    // mode is ignored: ld follows sw_stable even with mode=1
    bus.mode = 1'b1;
    bus.sw   = 8'h01;
    step(6);
    chk_all("nomode_press", 8'h01, 8'h01, 8'h00);
    step(1);
    chk("nomode_press.ld", bus.ld, 8'h01);
    bus.sw = 8'h00;
    step(6);
    chk("nomode_rel.st", bus.sw_stable, 8'h00);
    step(1);
    chk("nomode_rel.ld", bus.ld, 8'h00);
    bus.mode = 1'b0;
`endif

    // reset mid-count on sw[5] while sw[0] is already stable high
    bus.mode = 1'b0;
    bus.sw   = 8'h01;
    step(7);
    chk_all("rst_pre", 8'h01, 8'h00, 8'h01);
    bus.sw = 8'h21;
    step(4);
    chk("rst_midcount.ld", bus.ld, 8'h01);
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(5);
    chk_all("rst_post5", 8'h00, 8'h00, 8'h00);
    step(1);
    chk_all("rst_post6", 8'h21, 8'h21, 8'h00);
    step(1);
    chk_all("rst_post7", 8'h21, 8'h00, 8'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
